// File: rtl/f_ifu_if.sv
// Fetch-unit bus: D-stage redirect inputs, IM word, and the PC / F-D register outputs.
interface f_ifu_if;
    logic        stall;
    logic [31:0] f_instr;
    logic [31:0] d_pc;
    logic        d_branch;
    logic        cmp_result;
    logic [1:0]  d_jump_type;
    logic [15:0] d_imm16;
    logic [25:0] d_index26;
    logic [31:0] d_rs_fwd;
    logic [31:0] f_pc;
    logic [31:0] fd_instr;
    logic [31:0] fd_pc;
    logic        redirect;

    modport master (
        output stall, f_instr, d_pc, d_branch, cmp_result, d_jump_type,
               d_imm16, d_index26, d_rs_fwd,
        input  f_pc, fd_instr, fd_pc, redirect
    );

    modport slave (
        input  stall, f_instr, d_pc, d_branch, cmp_result, d_jump_type,
               d_imm16, d_index26, d_rs_fwd,
        output f_pc, fd_instr, fd_pc, redirect
    );
endinterface

// File: rtl/f_ifu.sv
// MIPS fetch stage: PC register, next-PC selection from D-stage redirects, F/D register.
// Branch delay slot is architectural: nothing is flushed here.
module f_ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic    clk,
    input  logic    reset,
    f_ifu_if.slave  bus
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        JT_NONE = 2'b00,
        JT_J    = 2'b01,
        JT_JR   = 2'b10,
        JT_RSVD = 2'b11
    } jump_type_e;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] fd_instr_q;
    logic [XLEN-1:0] fd_pc_q;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] d_pc_plus4;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] j_target;
    logic            redirect_c;
    jump_type_e      jt;

    // Redirect targets, all from D-stage fields; arithmetic wraps mod 2^32
    always_comb begin
        jt         = jump_type_e'(bus.d_jump_type);
        seq_pc     = pc_q + XLEN'(4);
        d_pc_plus4 = bus.d_pc + XLEN'(4);
        br_target  = d_pc_plus4 + {{14{bus.d_imm16[15]}}, bus.d_imm16, 2'b00};
        j_target   = {d_pc_plus4[31:28], bus.d_index26, 2'b00};
    end

    // Next-PC priority: stall, jr, j, taken branch, sequential
    always_comb begin
        next_pc    = seq_pc;
        redirect_c = 1'b0;
        if (bus.stall) begin
            next_pc = pc_q;
        end else begin
            unique case (jt)
                JT_JR: begin
                    next_pc    = bus.d_rs_fwd;
                    redirect_c = 1'b1;
                end
                JT_J: begin
                    next_pc    = j_target;
                    redirect_c = 1'b1;
                end
                JT_NONE, JT_RSVD: begin
                    if (bus.d_branch && bus.cmp_result) begin
                        next_pc    = br_target;
                        redirect_c = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // PC and F/D register; reset contents decode as nop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            fd_instr_q <= '0;
            fd_pc_q    <= '0;
        end else if (!bus.stall) begin
            pc_q       <= next_pc;
            fd_instr_q <= bus.f_instr;
            fd_pc_q    <= pc_q;
        end
    end

    assign bus.f_pc     = pc_q;
    assign bus.fd_instr = fd_instr_q;
    assign bus.fd_pc    = fd_pc_q;
    assign bus.redirect = redirect_c;
endmodule

// File: tb/tb_f_ifu.sv
// Directed bench for f_ifu: reset, sequential fetch, branches, jumps, stall and PC wrap.
`timescale 1ns/1ps
module tb_f_ifu;
    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    f_ifu_if bus ();

    f_ifu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: distinct word per address
    function automatic logic [31:0] im(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    assign bus.f_instr = im(bus.f_pc);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [31:0] pc, input logic br, input logic cmp,
                         input logic [1:0] jt, input logic [15:0] imm,
                         input logic [25:0] idx, input logic [31:0] rs);
        bus.d_pc        = pc;
        bus.d_branch    = br;
        bus.cmp_result  = cmp;
        bus.d_jump_type = jt;
        bus.d_imm16     = imm;
        bus.d_index26   = idx;
        bus.d_rs_fwd    = rs;
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        reset     = 1'b1;
        bus.stall = 1'b0;
        set_d(32'h0, 1'b0, 1'b0, 2'b00, 16'h0, 26'h0, 32'h0);

        #2;
        chk("rst_f_pc",     bus.f_pc,     32'h0000_3000);
        chk("rst_fd_instr", bus.fd_instr, 32'h0);
        chk("rst_fd_pc",    bus.fd_pc,    32'h0);
        reset = 1'b0;

        tick();
        chk("first_f_pc",     bus.f_pc,     32'h0000_3004);
        chk("first_fd_pc",    bus.fd_pc,    32'h0000_3000);
        chk("first_fd_instr", bus.fd_instr, im(32'h0000_3000));
        tick(); tick(); tick();
        chk("seq_f_pc", bus.f_pc, 32'h0000_3010);

        // Asynchronous reset mid-cycle
        #2;
        reset = 1'b1;
        #1;
        chk("async_f_pc",     bus.f_pc,     32'h0000_3000);
        chk("async_fd_instr", bus.fd_instr, 32'h0);
        chk("async_fd_pc",    bus.fd_pc,    32'h0);
        reset = 1'b0;
        tick(); tick(); tick();
        chk("rel3_f_pc",     bus.f_pc,     32'h0000_300C);
        chk("rel3_fd_pc",    bus.fd_pc,    32'h0000_3008);
        chk("rel3_fd_instr", bus.fd_instr, im(32'h0000_3008));

        // jr back to 0x3008 to line up the beq scenario
        set_d(32'h0, 1'b0, 1'b0, 2'b10, 16'h0, 26'h0, 32'h0000_3008);
        #1;
        chk("jr_redirect", 32'(bus.redirect), 32'd1);
        tick();
        chk("jr_f_pc", bus.f_pc, 32'h0000_3008);

        // Taken beq forward; delay slot 0x3008 enters F/D
        set_d(32'h0000_3004, 1'b1, 1'b1, 2'b00, 16'h0003, 26'h0, 32'h0);
        #1;
        chk("beq_redirect", 32'(bus.redirect), 32'd1);
        tick();
        chk("beq_f_pc",     bus.f_pc,     32'h0000_3014);
        chk("beq_slot_pc",  bus.fd_pc,    32'h0000_3008);
        chk("beq_slot_ins", bus.fd_instr, im(32'h0000_3008));

        // Backward branch taken, then not taken
        set_d(32'h0000_3010, 1'b1, 1'b1, 2'b00, 16'hFFFE, 26'h0, 32'h0);
        tick();
        chk("bwd_f_pc", bus.f_pc, 32'h0000_300C);
        chk("bwd_fd_pc", bus.fd_pc, 32'h0000_3014);
        bus.cmp_result = 1'b0;
        #1;
        chk("nt_redirect", 32'(bus.redirect), 32'd0);
        tick();
        chk("nt_f_pc", bus.f_pc, 32'h0000_3010);

        // j with a simultaneous taken branch: jump wins
        set_d(32'h0000_3000, 1'b1, 1'b1, 2'b01, 16'h0003, 26'h000_0C40, 32'h0);
        #1;
        chk("j_redirect", 32'(bus.redirect), 32'd1);
        tick();
        chk("j_f_pc",  bus.f_pc,  32'h0000_3100);
        chk("j_fd_pc", bus.fd_pc, 32'h0000_3010);

        // jr with a simultaneous taken branch: jump wins
        set_d(32'h0000_3000, 1'b1, 1'b1, 2'b10, 16'h0003, 26'h000_0C40, 32'h0000_3ABC);
        tick();
        chk("jr2_f_pc", bus.f_pc, 32'h0000_3ABC);

        // Reserved jump type acts as none
        set_d(32'h0000_3000, 1'b0, 1'b0, 2'b11, 16'h0003, 26'h000_0C40, 32'h0000_1234);
        #1;
        chk("rsvd_redirect", 32'(bus.redirect), 32'd0);
        tick();
        chk("rsvd_f_pc", bus.f_pc, 32'h0000_3AC0);

        // Stall with a taken branch pending in D
        set_d(32'h0000_3004, 1'b1, 1'b1, 2'b00, 16'h0003, 26'h0, 32'h0);
        bus.stall = 1'b1;
        #1;
        chk("stall_redirect", 32'(bus.redirect), 32'd0);
        tick(); tick();
        chk("stall_f_pc",     bus.f_pc,     32'h0000_3AC0);
        chk("stall_fd_pc",    bus.fd_pc,    32'h0000_3ABC);
        chk("stall_fd_instr", bus.fd_instr, im(32'h0000_3ABC));
        bus.stall      = 1'b0;
        bus.cmp_result = 1'b0;
        #1;
        chk("unstall_redirect", 32'(bus.redirect), 32'd0);
        tick();
        chk("unstall_f_pc",  bus.f_pc,  32'h0000_3AC4);
        chk("unstall_fd_pc", bus.fd_pc, 32'h0000_3AC0);

        // PC wrap at top of address space
        set_d(32'h0, 1'b0, 1'b0, 2'b10, 16'h0, 26'h0, 32'hFFFF_FFFC);
        tick();
        chk("wrap_setup", bus.f_pc, 32'hFFFF_FFFC);
        bus.d_jump_type = 2'b00;
        tick();
        chk("wrap_f_pc",  bus.f_pc,  32'h0000_0000);
        chk("wrap_fd_pc", bus.fd_pc, 32'hFFFF_FFFC);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
